multicycle_shifter: RTL

//  Iterative, parametrised shifter; successor to the single-cycle sll/srl/sra units.

---
 rtl/multicycle_shifter_if.sv | 27 ++
 rtl/multicycle_shifter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/multicycle_shifter_if.sv
// Request/result handshake bundle for the iterative shifter.
// master = requester/consumer side, slave = the shifter unit.
interface multicycle_shifter_if #(
  parameter int N = 32
) ();
  localparam int SW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          busy;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/multicycle_shifter.sv
// Iterative shifter: applies at most STEP bits of shift per clock until shamt is consumed.
// Optional rotate-right on op 11 when SHIFTER_ROTATE_EN is defined; otherwise op 11 acts as SRL.
module multicycle_shifter #(
  parameter int N    = 32,
  parameter int STEP = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_shifter_if.slave   io_bus
);
  localparam int SW = $clog2(N);
  localparam int KW = $clog2(STEP) + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_operand;
  logic [SW-1:0] r_remaining;
  logic [1:0]    r_op;
  logic          r_sign;

  logic [KW-1:0] w_k;
  logic [SW-1:0] w_remaining_next;
  logic [N-1:0]  w_shifted;
  logic [1:0]    w_op_in;

  // One power-of-two slice of the shifter; SRA fills from the latched original sign bit.
  function automatic logic [N-1:0] shift_stage(
    input logic [N-1:0] v,
    input logic [1:0]   op,
    input logic         sign,
    input int           sh
  );
    logic [N-1:0] ones;
    ones = '1;
    case (op)
      OP_SLL:  return v << sh;
      OP_SRA:  return (v >> sh) | (sign ? ~(ones >> sh) : '0);
`ifdef SHIFTER_ROTATE_EN
      OP_ROR:  return (v >> sh) | (v << (N - sh));
`endif
      default: return v >> sh;
    endcase
  endfunction

  always_comb begin
    w_op_in = io_bus.in_op;
`ifndef SHIFTER_ROTATE_EN
    if (io_bus.in_op == OP_ROR) begin
      w_op_in = OP_SRL;
    end
`endif
  end

  // k = min(remaining, STEP)
  always_comb begin
    if (32'(r_remaining) < STEP) begin
      w_k = KW'(r_remaining);
    end else begin
      w_k = KW'(STEP);
    end
    w_remaining_next = r_remaining - SW'(w_k);
  end

  always_comb begin
    w_shifted = r_operand;
    for (int j = 0; j < KW; j++) begin
      if (w_k[j]) begin
        w_shifted = shift_stage(w_shifted, r_op, r_sign, 1 << j);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.in_valid)          w_state_next = S_SHIFT;
      S_SHIFT: if (w_remaining_next == '0)   w_state_next = S_DONE;
      S_DONE:  if (io_bus.out_ready)         w_state_next = S_IDLE;
      default:                               w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    io_bus.in_ready  = 1'b0;
    io_bus.out_valid = 1'b0;
    io_bus.out_data  = '0;
    io_bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        io_bus.in_ready = 1'b1;
      end
      S_SHIFT: begin
        io_bus.busy = 1'b1;
      end
      S_DONE: begin
        io_bus.out_valid = 1'b1;
        io_bus.out_data  = r_operand;
        io_bus.busy      = 1'b1;
      end
      default: begin
        io_bus.in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_operand   <= '0;
      r_remaining <= '0;
      r_op        <= OP_SLL;
      r_sign      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid) begin
            r_operand   <= io_bus.in_data;
            r_remaining <= io_bus.in_shamt;
            r_op        <= w_op_in;
            r_sign      <= io_bus.in_data[N-1];
          end
        end
        S_SHIFT: begin
          r_operand   <= w_shifted;
          r_remaining <= w_remaining_next;
        end
        default: begin
          r_remaining <= r_remaining;
        end
      endcase
    end
  end
endmodule
